fetch_controller: RTL and testbench

Sequencing controller for the instruction-fetch path: owns the program counter, issues single-outstanding requests to instruction memory, and hands fetched instructions to decode over a valid/ready handshake. Sits between the instruction memory and the decode stage. Accepts branch/jump redirects from execute and flushes any in-flight or held fetch. Replaces the free-running PC-to-memory wiring with a stall- and redirect-aware front end.

---
 rtl/fetch_controller.sv | 171 +++++++++++++++++
 tb/tb_fetch_controller.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Instruction-fetch front end. It owns the program counter and keeps at most
// one request outstanding to instruction memory. Each fetched word is held
// for decode until decode accepts it. A taken branch/jump from execute
// (redirect) flushes any in-flight or held fetch and restarts fetching at
// the new target.
//
// Handshakes (strict valid/ready semantics):
//   - mem_req/mem_gnt   : a request is accepted in the cycle where both are 1.
//                         While mem_req=1 and not yet granted, mem_addr is held
//                         stable. Exactly one mem_rvalid pulse returns for each
//                         accepted request, at the earliest one cycle later.
//   - if_valid/if_ready : an instruction transfers in the cycle where both are
//                         1 and redirect_valid=0. While if_valid=1 and no
//                         transfer happens, if_instr and if_pc stay stable.
//                         A redirect in that cycle flushes the word instead.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   mem_req, mem_addr     fetch request and address (mem_addr is the pc)
//   mem_gnt               memory accepts the request this cycle
//   mem_rvalid, mem_rdata read response
//   if_valid, if_ready    instruction handshake towards decode
//   if_instr, if_pc       held instruction word and its address
//   redirect_valid/target branch/jump restart; target[1:0] are ignored
//   fetch_count           completed decode transfers (wraps at 2^32)
//   dbg_state             current controller state, for observation only
// -----------------------------------------------------------------------------
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] fetch_count,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,  // one quiet cycle after reset
    S_REQ  = 3'd1,  // presenting a request at pc
    S_WAIT = 3'd2,  // request accepted, waiting for its response
    S_HOLD = 3'd3,  // word held for decode
    S_DROP = 3'd4   // response still owed, but the fetch was redirected away
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  // Instructions are word aligned, so the low target bits are forced to zero.
  logic [31:0] target_aligned;
  logic        unused_target_bits;

  assign target_aligned     = {redirect_target[31:2], 2'b00};
  assign unused_target_bits = ^redirect_target[1:0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      if_instr_q    <= 32'h0;
      if_pc_q       <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic. A redirect always wins over memory
  // acceptance and decode transfer in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    fetch_count_d = fetch_count_q;
    mem_req       = 1'b0;
    if_valid      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        // The request is withdrawn in a redirect cycle so memory never
        // accepts a fetch from the path being abandoned.
        mem_req = !redirect_valid;
        if (redirect_valid) begin
          pc_d = target_aligned;
        end else if (mem_gnt) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_rvalid && !redirect_valid) begin
          if_instr_d = mem_rdata;
          if_pc_d    = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = S_HOLD;
        end else if (mem_rvalid && redirect_valid) begin
          // Response arrives together with the redirect: nothing is owed any
          // more, so fetching can restart immediately.
          pc_d    = target_aligned;
          state_d = S_REQ;
        end else if (redirect_valid) begin
          // The response is still owed; it must be swallowed before a new
          // request goes out, otherwise it would be mistaken for the new one.
          pc_d    = target_aligned;
          state_d = S_DROP;
        end
      end

      S_DROP: begin
        if (redirect_valid) begin
          pc_d = target_aligned;
        end
        if (mem_rvalid) begin
          state_d = S_REQ;
        end
      end

      S_HOLD: begin
        if_valid = 1'b1;
        if (redirect_valid) begin
          pc_d    = target_aligned;
          state_d = S_REQ;
        end else if (if_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr    = pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign fetch_count = fetch_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] fetch_count;
  logic [2:0]  dbg_state;

  // Second DUT with a reset pc at the top of the address space
  logic        hi_mem_req, hi_mem_gnt, hi_mem_rvalid;
  logic [31:0] hi_mem_addr, hi_mem_rdata;
  logic        hi_if_valid, hi_if_ready;
  logic [31:0] hi_if_instr, hi_if_pc;
  logic [31:0] hi_fetch_count;
  logic [2:0]  hi_dbg_state;

  fetch_controller #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk(clk), .rst(rst),
    .mem_req(hi_mem_req), .mem_addr(hi_mem_addr), .mem_gnt(hi_mem_gnt),
    .mem_rvalid(hi_mem_rvalid), .mem_rdata(hi_mem_rdata),
    .if_valid(hi_if_valid), .if_ready(hi_if_ready), .if_instr(hi_if_instr), .if_pc(hi_if_pc),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .fetch_count(hi_fetch_count), .dbg_state(hi_dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];      // addresses of accepted requests still owed a response
  logic [31:0] exp_pc;        // address of the next instruction decode must receive
  logic [31:0] exp_count;     // transfers decode has accepted
  int          out_cnt;       // cycles until the owed response is returned
  int          lat_sel;       // response delay for the next request, -1 = random

  logic [31:0] hi_addrs[$];
  logic        hi_pend;
  logic [31:0] hi_last_addr;

  // Observations of the most recent cycle
  logic        o_mem_req, o_if_valid, o_accept, o_transfer;
  logic [31:0] o_mem_addr, o_if_pc, o_if_instr, o_fetch_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_pc    = 32'h0000_0000;
    exp_count = 32'h0;
    out_cnt   = 0;
    hi_pend   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Inputs are driven after the falling edge, outputs
  // sampled 1ns later, and the reference model advanced by what the coming
  // rising edge will commit.
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic gnt, input logic rdy, input logic redir, input logic [31:0] tgt);
    @(negedge clk);
    mem_gnt         = gnt;
    if_ready        = rdy;
    redirect_valid  = redir;
    redirect_target = tgt;
    mem_rvalid      = (exp_q.size() != 0) && (out_cnt == 0);
    mem_rdata       = mem_rvalid ? mem_word(exp_q[0]) : $urandom();
    hi_mem_gnt      = 1'b1;
    hi_if_ready     = 1'b1;
    hi_mem_rvalid   = hi_pend;
    hi_mem_rdata    = hi_pend ? mem_word(hi_last_addr) : $urandom();
    #1;
    o_mem_req     = mem_req;
    o_mem_addr    = mem_addr;
    o_if_valid    = if_valid;
    o_if_pc       = if_pc;
    o_if_instr    = if_instr;
    o_fetch_count = fetch_count;

    check_eq("fetch_count", fetch_count, exp_count);
    if (redir) check_eq("req_gated_by_redirect", {31'h0, mem_req}, 32'h0);
    if (if_valid) check_eq("req_while_valid", {31'h0, mem_req}, 32'h0);

    o_accept = mem_req && gnt;
    if (o_accept) begin
      check_eq("outstanding_at_req", exp_q.size(), 0);
      check_eq("req_addr", mem_addr, exp_pc);
    end

    o_transfer = if_valid && rdy && !redir;
    if (o_transfer) begin
      check_eq("xfer_pc", if_pc, exp_pc);
      check_eq("xfer_instr", if_instr, mem_word(exp_pc));
      exp_pc    = exp_pc + 32'd4;
      exp_count = exp_count + 32'd1;
    end
    if (redir) exp_pc = {tgt[31:2], 2'b00};

    if (mem_rvalid) void'(exp_q.pop_front());
    else if (exp_q.size() != 0) out_cnt--;
    if (o_accept) begin
      exp_q.push_back(mem_addr);
      out_cnt = (lat_sel < 0) ? int'($urandom_range(0, 3)) : lat_sel;
    end

    if (hi_if_valid) check_eq("hi_instr", hi_if_instr, mem_word(hi_if_pc));
    if (hi_mem_req) begin
      if (hi_addrs.size() < 2) hi_addrs.push_back(hi_mem_addr);
      hi_last_addr = hi_mem_addr;
      hi_pend = 1'b1;
    end else begin
      hi_pend = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic        seen_req [0:9];
  logic        seen_vld [0:9];
  logic [31:0] seen_addr[0:9];
  logic [31:0] seen_pc  [0:9];
  logic [31:0] save_pc, save_instr, save_cnt;
  logic        found;

  initial begin
    mem_gnt = 0; if_ready = 0; redirect_valid = 0; redirect_target = 0;
    mem_rvalid = 0; mem_rdata = 0;
    hi_mem_gnt = 0; hi_if_ready = 0; hi_mem_rvalid = 0; hi_mem_rdata = 0;
    hi_last_addr = 0;
    lat_sel = 0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Streaming with an always-ready memory and decode
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (c == 0) begin
        check_eq("rst_mem_addr", o_mem_addr, 32'h0);
        check_eq("rst_if_pc", o_if_pc, 32'h0);
        check_eq("rst_if_instr", o_if_instr, 32'h0);
      end
      seen_req[c] = o_mem_req; seen_vld[c] = o_if_valid;
      seen_addr[c] = o_mem_addr; seen_pc[c] = o_if_pc;
    end
    for (int c = 0; c < 10; c++) begin
      check_eq("stream_req", {31'h0, seen_req[c]}, {31'h0, (c % 3) == 1});
      check_eq("stream_valid", {31'h0, seen_vld[c]}, {31'h0, (c % 3) == 0 && c > 0});
      if ((c % 3) == 1) check_eq("stream_addr", seen_addr[c], 32'(4 * ((c - 1) / 3)));
      if ((c % 3) == 0 && c > 0) check_eq("stream_if_pc", seen_pc[c], 32'(4 * (c / 3 - 1)));
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("stream_count", o_fetch_count, 32'd3);

    // Decode stalls for 5 cycles while a word is held
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      found = o_if_valid;
    end
    check_eq("stall_reach_hold", {31'h0, found}, 32'h1);
    save_pc = o_if_pc; save_instr = o_if_instr; save_cnt = o_fetch_count;
    repeat (5) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("stall_valid", {31'h0, o_if_valid}, 32'h1);
      check_eq("stall_pc", o_if_pc, save_pc);
      check_eq("stall_instr", o_if_instr, save_instr);
      check_eq("stall_no_req", {31'h0, o_mem_req}, 32'h0);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("stall_count", o_fetch_count, save_cnt + 32'd1);
    check_eq("stall_released", {31'h0, o_if_valid}, 32'h0);

    // Redirect while waiting; the stale response comes 3 cycles later
    lat_sel = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      found = o_accept;
    end
    check_eq("wait_reach_accept", {31'h0, found}, 32'h1);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    lat_sel = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      found = o_mem_req;
      if (!found) check_eq("drop_no_valid", {31'h0, o_if_valid}, 32'h0);
    end
    check_eq("drop_req_seen", {31'h0, found}, 32'h1);
    check_eq("drop_new_addr", o_mem_addr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      found = o_if_valid;
    end
    check_eq("redir_valid_seen", {31'h0, found}, 32'h1);
    check_eq("redir_if_pc", o_if_pc, 32'h0000_0100);
    check_eq("redir_if_instr", o_if_instr, mem_word(32'h0000_0100));

    // Redirect in HOLD together with if_ready: no transfer
    save_cnt = o_fetch_count;
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_2000);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("hold_redir_count", o_fetch_count, save_cnt);
    check_eq("hold_redir_req", {31'h0, o_mem_req}, 32'h1);
    check_eq("hold_redir_addr", o_mem_addr, 32'h0000_2000);
    check_eq("hold_redir_valid", {31'h0, o_if_valid}, 32'h0);

    // Randomized traffic against the reference model
    lat_sel = -1;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0, $urandom());
    end

    // Reset asserted in the middle of WAIT
    lat_sel = 5;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      found = o_accept && (o_mem_addr != 32'h0);
    end
    check_eq("midrst_reach_accept", {31'h0, found}, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("midrst_if_valid", {31'h0, if_valid}, 32'h0);
    check_eq("midrst_mem_addr", mem_addr, 32'h0);
    check_eq("midrst_if_pc", if_pc, 32'h0);
    check_eq("midrst_if_instr", if_instr, 32'h0);
    check_eq("midrst_count", fetch_count, 32'h0);
    model_reset();
    lat_sel = 0;
    mem_rvalid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      found = o_mem_req;
    end
    check_eq("midrst_req_seen", {31'h0, found}, 32'h1);
    check_eq("midrst_first_addr", o_mem_addr, 32'h0);

    // Top-of-memory reset pc wraps to address 0
    check_eq("hi_fetch_cnt", hi_addrs.size(), 2);
    if (hi_addrs.size() >= 2) begin
      check_eq("hi_first_addr", hi_addrs[0], 32'hFFFF_FFFC);
      check_eq("hi_second_addr", hi_addrs[1], 32'h0000_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
